mem_router: RTL

//  Parametrised memory router between the core's single memory port and NUM_REGIONS

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_region_decode.sv | 51 +++++
 rtl/mem_router.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory router: access widths, fault cause codes and FSM states.
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_UNMAPPED   = 3'd1,
        CAUSE_MISALIGNED = 3'd2,
        CAUSE_RO_WRITE   = 3'd3,
        CAUSE_TIMEOUT    = 3'd4,
        CAUSE_ILLEGAL    = 3'd5
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] width);
        logic result;
        case (width)
            MEM_H:   result = addr_lo[0];
            MEM_W:   result = (addr_lo != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decoder: finds the lowest-index region containing addr and classifies faults.
module mem_region_decode
    import mem_pkg::*;
#(
    parameter int                            NUM_REGIONS = 2,
    parameter int                            IDX_W       = 1,
    parameter logic [NUM_REGIONS*32-1:0]     REGION_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*32-1:0]     REGION_SIZE = {32'h0000_1000, 32'h0000_1000},
    parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 2'b01
) (
    input  logic [31:0]      addr,
    input  logic [1:0]       width,
    input  logic             write,
    output logic [IDX_W-1:0] hit_idx,
    output logic             hit,
    output fault_cause_e     cause
);

    logic [NUM_REGIONS-1:0] hit_v_s;
    logic                   ro_sel_s;

    // 33-bit bounds so a region ending at 4 GiB never wraps around to zero
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_hit
        assign hit_v_s[g] = ({1'b0, addr} >= {1'b0, REGION_BASE[g*32 +: 32]}) &&
                            ({1'b0, addr} <  ({1'b0, REGION_BASE[g*32 +: 32]} +
                                              {1'b0, REGION_SIZE[g*32 +: 32]}));
    end

    // Priority select (lowest index wins) and fault classification
    always_comb begin
        hit_idx  = '0;
        ro_sel_s = 1'b0;
        hit      = |hit_v_s;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            hit_idx  = hit_v_s[i] ? IDX_W'(i)    : hit_idx;
            ro_sel_s = hit_v_s[i] ? REGION_RO[i] : ro_sel_s;
        end
        if (width == 2'b11) begin
            cause = CAUSE_ILLEGAL;
        end else if (!hit) begin
            cause = CAUSE_UNMAPPED;
        end else if (is_misaligned(addr[1:0], width)) begin
            cause = CAUSE_MISALIGNED;
        end else if (write && ro_sel_s) begin
            cause = CAUSE_RO_WRITE;
        end else begin
            cause = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/mem_router.sv
// Routes the core's single memory port to one of NUM_REGIONS targets with protection,
// alignment checking, target timeout and fault reporting.
module mem_router
    import mem_pkg::*;
#(
    parameter int                            NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0]     REGION_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*32-1:0]     REGION_SIZE = {32'h0000_1000, 32'h0000_1000},
    parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 2'b01,
    parameter int                            TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               mem_addr,
    input  logic                      mem_read_valid,
    input  logic                      mem_write_valid,
    input  logic [31:0]               mem_write_data,
    input  logic [1:0]                mem_width,
    output logic [31:0]               mem_read_data,
    output logic                      mem_ready,
    output logic                      mem_fault,
    output logic [2:0]                mem_fault_cause,
    output logic [NUM_REGIONS*32-1:0] tgt_addr,
    output logic [NUM_REGIONS-1:0]    tgt_read_valid,
    output logic [NUM_REGIONS-1:0]    tgt_write_valid,
    output logic [31:0]               tgt_write_data,
    output logic [1:0]                tgt_width,
    input  logic [NUM_REGIONS*32-1:0] tgt_read_data,
    input  logic [NUM_REGIONS-1:0]    tgt_ready
);

    localparam int          IDX_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam bit          TIMEOUT_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_e                 state_r, next_state_s;
    logic [IDX_W-1:0]       sel_r, strobe_sel_s, dec_idx_s;
    logic                   is_write_r, strobe_write_s;
    logic [31:0]            count_r;
    logic                   dec_hit_s;
    fault_cause_e           dec_cause_s, req_cause_s, fault_cause_s;
    logic                   req_s, sel_ready_s;
    logic [31:0]            sel_rdata_s;
    logic [NUM_REGIONS-1:0] next_rv_s, next_wv_s;

    mem_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE),
        .REGION_RO   (REGION_RO)
    ) u_decode (
        .addr    (mem_addr),
        .width   (mem_width),
        .write   (mem_write_valid),
        .hit_idx (dec_idx_s),
        .hit     (dec_hit_s),
        .cause   (dec_cause_s)
    );

    assign req_s       = mem_read_valid | mem_write_valid;
    assign req_cause_s = (mem_read_valid && mem_write_valid) ? CAUSE_ILLEGAL : dec_cause_s;
    assign sel_ready_s = tgt_ready[sel_r];
    assign sel_rdata_s = tgt_read_data[sel_r*32 +: 32];

    // Next-state, fault cause and next target strobes
    always_comb begin
        next_state_s   = state_r;
        fault_cause_s  = CAUSE_NONE;
        next_rv_s      = '0;
        next_wv_s      = '0;
        strobe_sel_s   = (state_r == ST_IDLE) ? dec_idx_s : sel_r;
        strobe_write_s = (state_r == ST_IDLE) ? mem_write_valid : is_write_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_s) begin
                    next_state_s = ST_IDLE;
                end else if (req_cause_s != CAUSE_NONE) begin
                    next_state_s  = ST_FAULT;
                    fault_cause_s = req_cause_s;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (sel_ready_s) begin
                    next_state_s = ST_RESP;
                end else if (TIMEOUT_EN && (count_r == TIMEOUT_LAST)) begin
                    next_state_s  = ST_FAULT;
                    fault_cause_s = CAUSE_TIMEOUT;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_RESP:  next_state_s = ST_IDLE;
            ST_FAULT: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
        if (next_state_s == ST_ACCESS) begin
            next_rv_s[strobe_sel_s] = !strobe_write_s;
            next_wv_s[strobe_sel_s] = strobe_write_s;
        end else begin
            next_rv_s = '0;
            next_wv_s = '0;
        end
    end

    // State, request capture, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            sel_r           <= '0;
            is_write_r      <= 1'b0;
            count_r         <= 32'd0;
            mem_ready       <= 1'b0;
            mem_fault       <= 1'b0;
            mem_fault_cause <= 3'd0;
            mem_read_data   <= 32'd0;
            tgt_addr        <= '0;
            tgt_read_valid  <= '0;
            tgt_write_valid <= '0;
            tgt_write_data  <= 32'd0;
            tgt_width       <= 2'd0;
        end else begin
            state_r         <= next_state_s;
            mem_ready       <= (next_state_s == ST_RESP) || (next_state_s == ST_FAULT);
            mem_fault       <= (next_state_s == ST_FAULT);
            mem_fault_cause <= (next_state_s == ST_FAULT) ? fault_cause_s : 3'd0;
            mem_read_data   <= ((state_r == ST_ACCESS) && (next_state_s == ST_RESP) && !is_write_r)
                               ? sel_rdata_s : 32'd0;
            tgt_read_valid  <= next_rv_s;
            tgt_write_valid <= next_wv_s;
            if ((state_r == ST_IDLE) && (next_state_s == ST_ACCESS)) begin
                sel_r          <= dec_idx_s;
                is_write_r     <= mem_write_valid;
                tgt_write_data <= mem_write_data;
                tgt_width      <= mem_width;
                count_r        <= 32'd0;
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    tgt_addr[i*32 +: 32] <= mem_addr - REGION_BASE[i*32 +: 32];
                end
            end else if (state_r == ST_ACCESS) begin
                count_r <= count_r + 32'd1;
            end
        end
    end

endmodule
